// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - Issue-side and ALU-command-side signals of the decode/issue stage.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch_eq;
  logic        branch_ne;
  logic        illegal;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_control, alu_a, alu_b, dest,
    input  reg_write, mem_read, mem_write, branch_eq, branch_ne, illegal
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, alu_control, alu_a, alu_b, dest,
    output reg_write, mem_read, mem_write, branch_eq, branch_ne, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS decode/issue stage feeding the ALU through the ID/EX register.
// Optional load-use interlock: ALU_ISSUE_LOAD_USE_INTERLOCK_EN.
module alu_issue_stage (
  input logic              i_clk,
  input logic              i_reset,
  alu_issue_stage_if.slave bus
);
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_NOR = 3'd3,
    ALU_OR  = 3'd4, ALU_XOR = 3'd5, ALU_SLT = 3'd6
  } alu_op_t;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [2:0]  w_ctl;
  logic [31:0] w_b;
  logic [4:0]  w_dest;
  logic        w_rw, w_mr, w_mw, w_beq, w_bne, w_ill;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_stall;
  logic        w_unused_shamt;

  logic        r_out_valid;
  logic [2:0]  r_alu_control;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_dest;
  logic        r_reg_write, r_mem_read, r_mem_write, r_branch_eq, r_branch_ne, r_illegal;

  assign w_op           = bus.instr[31:26];
  assign w_funct        = bus.instr[5:0];
  assign w_sext         = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign w_zext         = {16'h0000, bus.instr[15:0]};
  assign w_unused_shamt = ^bus.instr[10:6];

  always_comb begin
    w_ctl  = ALU_ADD;
    w_b    = bus.rt_data;
    w_dest = 5'd0;
    w_rw   = 1'b0;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_beq  = 1'b0;
    w_bne  = 1'b0;
    w_ill  = 1'b0;
    case (w_op)
      6'h00: begin
        w_dest = bus.instr[15:11];
        w_rw   = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_ctl = ALU_ADD;
          6'h22, 6'h23: w_ctl = ALU_SUB;
          6'h24:        w_ctl = ALU_AND;
          6'h25:        w_ctl = ALU_OR;
          6'h26:        w_ctl = ALU_XOR;
          6'h27:        w_ctl = ALU_NOR;
          6'h2A:        w_ctl = ALU_SLT;
          default: begin
            w_ill  = 1'b1;
            w_dest = 5'd0;
            w_rw   = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin w_ctl = ALU_ADD; w_b = w_sext; w_dest = bus.instr[20:16]; w_rw = 1'b1; end
      6'h0A:        begin w_ctl = ALU_SLT; w_b = w_sext; w_dest = bus.instr[20:16]; w_rw = 1'b1; end
      6'h0C:        begin w_ctl = ALU_AND; w_b = w_zext; w_dest = bus.instr[20:16]; w_rw = 1'b1; end
      6'h0D:        begin w_ctl = ALU_OR;  w_b = w_zext; w_dest = bus.instr[20:16]; w_rw = 1'b1; end
      6'h0E:        begin w_ctl = ALU_XOR; w_b = w_zext; w_dest = bus.instr[20:16]; w_rw = 1'b1; end
      6'h23: begin
        w_ctl  = ALU_ADD;
        w_b    = w_sext;
        w_dest = bus.instr[20:16];
        w_rw   = 1'b1;
        w_mr   = 1'b1;
      end
      6'h2B: begin w_ctl = ALU_ADD; w_b = w_sext; w_mw = 1'b1; end
      6'h04: begin w_ctl = ALU_SUB; w_beq = 1'b1; end
      6'h05: begin w_ctl = ALU_SUB; w_bne = 1'b1; end
      default: w_ill = 1'b1;
    endcase
    // Writes to $0 are discarded, so they are issued as non-writing.
    if (w_dest == 5'd0) w_rw = 1'b0;
  end

`ifdef ALU_ISSUE_LOAD_USE_INTERLOCK_EN
  logic w_reads_rt;
  assign w_reads_rt = (w_op == 6'h00) || (w_op == 6'h2B) || (w_op == 6'h04) || (w_op == 6'h05);
  assign w_hazard   = r_out_valid && r_mem_read && (r_dest != 5'd0) && bus.in_valid &&
                      ((r_dest == bus.instr[25:21]) || ((r_dest == bus.instr[20:16]) && w_reads_rt));
`else
  assign w_hazard = 1'b0;
`endif

  // During flush the input is drained (ready high) but never loaded.
  assign w_in_ready = bus.flush || ((!r_out_valid || bus.out_ready) && !w_hazard);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_stall    = r_out_valid && !bus.out_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid   <= 1'b0;
      r_alu_control <= 3'd0;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_dest        <= 5'd0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch_eq   <= 1'b0;
      r_branch_ne   <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_alu_control <= w_ctl;
        r_alu_a       <= bus.rs_data;
        r_alu_b       <= w_b;
        r_dest        <= w_dest;
        r_reg_write   <= w_rw;
        r_mem_read    <= w_mr;
        r_mem_write   <= w_mw;
        r_branch_eq   <= w_beq;
        r_branch_ne   <= w_bne;
        r_illegal     <= w_ill;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.alu_control = r_alu_control;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.dest        = r_dest;
  assign bus.reg_write   = r_reg_write;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.branch_eq   = r_branch_eq;
  assign bus.branch_ne   = r_branch_ne;
  assign bus.illegal     = r_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - Directed vector and sequence bench for alu_issue_stage.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        rw, mr, mw, beq, bne, ill, chk_ops;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] rs, logic [31:0] rt,
                              logic [2:0] ctl, logic [31:0] b, logic [4:0] dest,
                              logic rw, logic mr, logic mw, logic beq, logic bne, logic ill);
    vec_t v;
    v.name = name; v.instr = instr; v.rs = rs; v.rt = rt; v.ctl = ctl; v.a = rs; v.b = b;
    v.dest = dest; v.rw = rw; v.mr = mr; v.mw = mw; v.beq = beq; v.bne = bne; v.ill = ill;
    v.chk_ops = !ill;
    return v;
  endfunction

  function automatic logic [31:0] pack(logic ov, logic ill, logic bne, logic beq, logic mw,
                                       logic mr, logic rw, logic [4:0] dest, logic [2:0] ctl);
    return {17'd0, ov, ill, bne, beq, mw, mr, rw, dest, ctl};
  endfunction

  function automatic logic [31:0] dut_ctrl();
    return pack(bus.out_valid, bus.illegal, bus.branch_ne, bus.branch_eq, bus.mem_write,
                bus.mem_read, bus.reg_write, bus.dest, bus.alu_control);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    bus.in_valid = v;
    bus.instr    = instr;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);

    vecs.push_back(mk("add",      32'h00221820, 32'd5, 32'hFFFFFFFD, 3'd0, 32'hFFFFFFFD, 5'd3, 1,0,0,0,0,0));
    vecs.push_back(mk("ori",      32'h34048001, 32'd0, 32'h12345678, 3'd4, 32'h00008001, 5'd4, 1,0,0,0,0,0));
    vecs.push_back(mk("slti",     32'h28048001, 32'd0, 32'h12345678, 3'd6, 32'hFFFF8001, 5'd4, 1,0,0,0,0,0));
    vecs.push_back(mk("sub",      32'h00223822, 32'd9, 32'd4,        3'd1, 32'd4,        5'd7, 1,0,0,0,0,0));
    vecs.push_back(mk("nor",      32'h00224027, 32'd9, 32'd4,        3'd3, 32'd4,        5'd8, 1,0,0,0,0,0));
    vecs.push_back(mk("xor",      32'h00224826, 32'd9, 32'd4,        3'd5, 32'd4,        5'd9, 1,0,0,0,0,0));
    vecs.push_back(mk("and",      32'h00225024, 32'd9, 32'd4,        3'd2, 32'd4,        5'd10,1,0,0,0,0,0));
    vecs.push_back(mk("slt",      32'h0022582A, 32'd9, 32'd4,        3'd6, 32'd4,        5'd11,1,0,0,0,0,0));
    vecs.push_back(mk("add_r0",   32'h00220020, 32'd1, 32'd2,        3'd0, 32'd2,        5'd0, 0,0,0,0,0,0));
    vecs.push_back(mk("addiu",    32'h2426FFFF, 32'd7, 32'd0,        3'd0, 32'hFFFFFFFF, 5'd6, 1,0,0,0,0,0));
    vecs.push_back(mk("andi",     32'h3026FFFF, 32'd7, 32'd0,        3'd2, 32'h0000FFFF, 5'd6, 1,0,0,0,0,0));
    vecs.push_back(mk("xori",     32'h3826FFFF, 32'd7, 32'd0,        3'd5, 32'h0000FFFF, 5'd6, 1,0,0,0,0,0));
    vecs.push_back(mk("lw",       32'h8C250004, 32'd64, 32'd0,       3'd0, 32'd4,        5'd5, 1,1,0,0,0,0));
    vecs.push_back(mk("lw_neg",   32'h8C25FFFC, 32'd64, 32'd0,       3'd0, 32'hFFFFFFFC, 5'd5, 1,1,0,0,0,0));
    vecs.push_back(mk("sw",       32'hAC25FFFC, 32'd64, 32'd77,      3'd0, 32'hFFFFFFFC, 5'd0, 0,0,1,0,0,0));
    vecs.push_back(mk("beq",      32'h10220010, 32'd3, 32'd3,        3'd1, 32'd3,        5'd0, 0,0,0,1,0,0));
    vecs.push_back(mk("bne",      32'h14220010, 32'd3, 32'd8,        3'd1, 32'd8,        5'd0, 0,0,0,0,1,0));
    vecs.push_back(mk("op3f",     32'hFC000000, 32'd3, 32'd8,        3'd0, 32'd0,        5'd0, 0,0,0,0,0,1));
    vecs.push_back(mk("bad_fn",   32'h00221800, 32'd3, 32'd8,        3'd0, 32'd0,        5'd0, 0,0,0,0,0,1));

    // Reset state
    step();
    step();
    chk("rst_ctrl", dut_ctrl(), 32'd0);
    chk("rst_a", bus.alu_a, 32'd0);
    chk("rst_b", bus.alu_b, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;

    // Table: back-to-back issue at full throughput
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      step();
      chk({vecs[i].name, "_ctrl"}, dut_ctrl(),
          pack(1'b1, vecs[i].ill, vecs[i].bne, vecs[i].beq, vecs[i].mw, vecs[i].mr,
               vecs[i].rw, vecs[i].dest, vecs[i].ctl));
      if (vecs[i].chk_ops) begin
        chk({vecs[i].name, "_a"}, bus.alu_a, vecs[i].a);
        chk({vecs[i].name, "_b"}, bus.alu_b, vecs[i].b);
      end
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Stall for three cycles with a new instruction waiting
    drive(1'b1, 32'h00221820, 32'd11, 32'd1);
    step();
    chk("stall_A_load", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd3,3'd0));
    drive(1'b1, 32'h00223822, 32'd22, 32'd2);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      chk("stall_ctrl_hold", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd3,3'd0));
      chk("stall_a_hold", bus.alu_a, 32'd11);
    end
    bus.out_ready = 1'b1;
    step();
    chk("stall_B_load", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd7,3'd1));
    chk("stall_B_a", bus.alu_a, 32'd22);
    drive(1'b1, 32'h00224027, 32'd33, 32'd3);
    step();
    chk("stall_C_load", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd8,3'd3));
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    chk("stall_end_valid", {31'd0, bus.out_valid}, 32'd0);

    // Load followed by a dependent add
    drive(1'b1, 32'h8C250000, 32'd100, 32'd0);
    step();
    chk("lu_lw", dut_ctrl(), pack(1,0,0,0,0,1,1,5'd5,3'd0));
    drive(1'b1, 32'h00A23020, 32'd200, 32'd3);
    #1;
`ifdef ALU_ISSUE_LOAD_USE_INTERLOCK_EN
    chk("lu_in_ready_hazard", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, bus.out_valid}, 32'd0);
    #1;
    chk("lu_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    step();
`else
    chk("lu_in_ready_nohaz", {31'd0, bus.in_ready}, 32'd1);
    step();
`endif
    chk("lu_add", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd6,3'd0));
    chk("lu_add_a", bus.alu_a, 32'd200);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // Flush during a stall with a valid incoming instruction
    drive(1'b1, 32'h00221820, 32'd1, 32'd2);
    step();
    chk("fl_load", dut_ctrl(), pack(1,0,0,0,0,0,1,5'd3,3'd0));
    drive(1'b1, 32'h00223822, 32'd4, 32'd5);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    chk("fl_dropped", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-stream
    drive(1'b1, 32'h8C25FFFC, 32'd64, 32'd9);
    step();
    chk("mr_load", dut_ctrl(), pack(1,0,0,0,0,1,1,5'd5,3'd0));
    reset = 1'b1;
    step();
    chk("mr_ctrl", dut_ctrl(), 32'd0);
    chk("mr_a", bus.alu_a, 32'd0);
    chk("mr_b", bus.alu_b, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
